dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised successor to the single-cycle data memory of the RISC-V datapath. It provides a byte-addressed data RAM behind a valid/ready request/response handshake, with RV32/RV64 load/store sizing, sign/zero extension, byte-lane write enables and misaligned/illegal access reporting. It sits between the EX/MEM pipeline stage and writeback. A pending response can stall the core through `req_ready`.

## Interface
- `ADDR_W`, 9: byte-address width. Depth = 2^ADDR_W / (DATA_W/8) words.
- `DATA_W`, 32: data width, 32 or 64. 64 enables LD/SD/LWU.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction bits 14:12.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready` at a rising edge.
- `rsp_rdata` out DATA_W: load result, extended to DATA_W. 0 for stores and errors.
- `rsp_err` out 1: access was misaligned or illegal.

## Operation
- States: IDLE (no response held) and RESP (response held).
- IDLE + accept → RESP. RESP + consume + no accept → IDLE. RESP + consume + accept → RESP with the new response. RESP + no consume → RESP, holding the response.
- `req_ready` = (state==IDLE) || `rsp_ready`. It is combinational and gives one access per cycle throughput.
- Word index = `req_addr[ADDR_W-1:log2(DATA_W/8)]`. Lane offset = the low bits.
- Loads:
  - 000 LB and 100 LBU: byte, signed / unsigned.
  - 001 LH and 101 LHU: half, signed / unsigned.
  - 010 LW: word, signed. 110 LWU: word, unsigned, 64-bit only.
  - 011 LD: 64-bit only.
  - The lane is selected by the offset, then extended.
- Stores:
  - 000 SB, 001 SH, 010 SW, 011 SD (64-bit only).
  - Data is replicated across lanes. The byte enable is shifted by the offset.
  - Lanes that are not enabled keep their value.
- Illegal funct3 gives `rsp_err`=1, no write, `rsp_rdata`=0. Illegal codes are: store 1xx; load 111; 011 and 110 when DATA_W=32.
- Misaligned accesses are handled per the Configuration section.
- The memory array is not reset. Contents are undefined until written and are retained across `rst_n`.

## Timing
- Load accepted at edge N: array read at edge N. `rsp_rdata` is valid from N until the consume edge.
- Store accepted at edge N: array written at edge N. The ack (`rsp_valid`) is visible after N.
- Write-then-read to the same address on consecutive accepts returns the new data. There is no hazard.
- Response registers do not change while in RESP without consume. A new accept that coincides with a consume replaces them at the same edge.
- While `rst_n`=0:
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state=IDLE, `req_ready`=1 (combinational).
  - No array writes occur.
- Reset asserted while in RESP drops the pending response. A store accepted on the same edge as reset assertion is not written.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: misaligned accesses give `rsp_err`=1. Stores do not write; loads return 0. Misaligned means:
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - double with addr[2:0]≠0.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - The offending low address bits are forced to 0 (aligned down).
  - The access completes normally with `rsp_err`=0.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10 and LW @0x10. Then LB @0x13 → 0xFFFFFFDE, LBU @0x13 → 0x000000DE, LH @0x12 → 0xFFFFDEAD.
- SB 0x5A @0x11 after the above, then LW @0x10 → 0xDEAD5AEF. Back-to-back accepts with `rsp_ready`=1 must give one response per cycle.
- Load with `rsp_ready`=0 for 3 cycles: `req_ready`=0, `rsp_rdata` held stable. On release, consume and the next accept occur on the same edge.
- LW @0x02:
  - with macro: `rsp_err`=1, `rsp_rdata`=0.
  - without macro: returns the word @0x00 with `rsp_err`=0.
- DATA_W=64:
  - SD 0x0123456789ABCDEF @0x8, then LWU @0xC → 0x0000000001234567, LD @0x8 → the full value.
  - DATA_W=32 with funct3 011 → `rsp_err`=1, memory unchanged.
- Assert `rst_n` low while in RESP, and with a store presented: `rsp_valid` falls immediately. A later read shows the old data at that address.

Source files
------------

// File: rtl/dmem_lsu.sv
// Byte-addressed data RAM with a valid/ready load/store interface, RV32/RV64 sizing and extension.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module dmem_lsu #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic [1:0]        size;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  align_mask;
    logic [OFF_W-1:0]  off_al;
    logic              misaligned;
    logic              misalign_err;
    logic              illegal;
    logic              err;
    logic              wr_en;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_val;
    logic              sign;
    int                width;

    assign req_ready = (state_q == StIdle) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign size = req_funct3[1:0];
    assign idx  = req_addr[ADDR_W-1:OFF_W];
    assign off  = req_addr[OFF_W-1:0];

    // Access decode: legality, alignment and the lane offset actually used.
    always_comb begin
        align_mask = '0;
        for (int b = 0; b < OFF_W; b++) begin
            align_mask[b] = (b < int'(size));
        end
        misaligned = |(off & align_mask);
        off_al     = off & ~align_mask;

`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_err = misaligned;
`else
        misalign_err = 1'b0;
`endif

        if (req_we) begin
            illegal = req_funct3[2] || ((DATA_W == 32) && (size == 2'b11));
        end else begin
            illegal = (req_funct3 == 3'b111) ||
                      ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        end

        err   = illegal || misalign_err;
        wr_en = accept && req_we && !err;
    end

    // Store path: replicate the right-aligned data into every lane, enable only the target bytes.
    always_comb begin
        be   = '0;
        wrep = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(off_al)) && (i < int'(off_al) + (1 << int'(size)));
            unique case (size)
                2'b00:   wrep[8*i +: 8] = req_wdata[7:0];
                2'b01:   wrep[8*i +: 8] = req_wdata[8*(i%2) +: 8];
                2'b10:   wrep[8*i +: 8] = req_wdata[8*(i%4) +: 8];
                default: wrep[8*i +: 8] = req_wdata[8*(i%8) +: 8];
            endcase
        end
    end

    // Load path: shift the addressed lane down, then sign- or zero-extend from its width.
    always_comb begin
        rd_word = mem[idx];
        lane    = rd_word >> {off_al, 3'b000};
        width   = 8 << int'(size);
        unique case (size)
            2'b00:   sign = lane[7];
            2'b01:   sign = lane[15];
            2'b10:   sign = lane[31];
            default: sign = lane[DATA_W-1];
        endcase
        sign = sign && !req_funct3[2];
        load_val = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_val[i] = (i < width) ? lane[i] : sign;
        end
    end

    // The array has no reset; writes are simply suppressed while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wrep[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StResp;
            StResp: if (rsp_ready && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_rdata_q <= (req_we || err) ? '0 : load_val;
                rsp_err_q   <= err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a 32-bit instance driven through the handshake and a 64-bit one.
module tb_dmem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [8:0]  b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [63:0] b_rsp_rdata;

    dmem_lsu #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_lsu #(.ADDR_W(9), .DATA_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(q.size()), 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
                chk({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accept edge with req_valid low.
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [8:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        int n;
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
                req_valid = 1'b0;
                return;
            end
        end
        e.tag = tag; e.rdata = er; e.err = ee;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic op64(input string tag, input logic we, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [63:0] wd,
                        input logic [63:0] er, input logic ee);
        b_req_valid  = 1'b1;
        b_req_we     = we;
        b_req_funct3 = f3;
        b_req_addr   = addr;
        b_req_wdata  = wd;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        chk({tag, "_valid"}, 64'(b_rsp_valid), 64'd1);
        chk({tag, "_rdata"}, b_rsp_rdata, er);
        chk({tag, "_err"}, 64'(b_rsp_err), 64'(ee));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0; b_req_addr = '0;
        b_req_wdata = '0; b_rsp_ready = 1'b1;

        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue("sw10", 1'b1, 3'b010, 9'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue("lw10", 1'b0, 3'b010, 9'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue("lb13", 1'b0, 3'b000, 9'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue("lbu13", 1'b0, 3'b100, 9'h13, 32'h0, 32'h000000DE, 1'b0);
        issue("lh12", 1'b0, 3'b001, 9'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue("sb11", 1'b1, 3'b000, 9'h11, 32'h0000005A, 32'h0, 1'b0);
        issue("lw10b", 1'b0, 3'b010, 9'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

        c0 = cyc;
        issue("b2b_lw", 1'b0, 3'b010, 9'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
        issue("b2b_lb", 1'b0, 3'b000, 9'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        issue("b2b_lhu", 1'b0, 3'b101, 9'h10, 32'h0, 32'h00005AEF, 1'b0);
        chk("b2b_cycles", 64'(cyc - c0), 64'd3);
        drain();

        issue("sw00", 1'b1, 3'b010, 9'h00, 32'h0BADF00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        issue("lw02_mis", 1'b0, 3'b010, 9'h02, 32'h0, 32'h0, 1'b1);
        issue("lh13_mis", 1'b0, 3'b001, 9'h13, 32'h0, 32'h0, 1'b1);
        issue("sh01_mis", 1'b1, 3'b001, 9'h01, 32'h00001111, 32'h0, 1'b1);
`else
        issue("lw02_mis", 1'b0, 3'b010, 9'h02, 32'h0, 32'h0BADF00D, 1'b0);
        issue("lh13_mis", 1'b0, 3'b001, 9'h13, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue("sh01_mis", 1'b1, 3'b001, 9'h01, 32'h00001111, 32'h0, 1'b0);
`endif
`ifdef DMEM_MISALIGN_TRAP_EN
        issue("lw00", 1'b0, 3'b010, 9'h00, 32'h0, 32'h0BADF00D, 1'b0);
`else
        issue("lw00", 1'b0, 3'b010, 9'h00, 32'h0, 32'h0BAD1111, 1'b0);
`endif

        issue("ld_ill", 1'b0, 3'b011, 9'h10, 32'h0, 32'h0, 1'b1);
        issue("lwu_ill", 1'b0, 3'b110, 9'h10, 32'h0, 32'h0, 1'b1);
        issue("l111_ill", 1'b0, 3'b111, 9'h10, 32'h0, 32'h0, 1'b1);
        issue("sd_ill", 1'b1, 3'b011, 9'h10, 32'h12345678, 32'h0, 1'b1);
        issue("s100_ill", 1'b1, 3'b100, 9'h10, 32'h12345678, 32'h0, 1'b1);
        issue("lw10_keep", 1'b0, 3'b010, 9'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
        drain();

        rsp_ready = 1'b0;
        issue("stall_lw", 1'b0, 3'b010, 9'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp_rdata", 64'(rsp_rdata), 64'hDEAD5AEF);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        c0 = cyc;
        issue("release_lb", 1'b0, 3'b000, 9'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        chk("release_same_edge", 64'(cyc - c0), 64'd1);
        chk("release_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();

        issue("sw20", 1'b1, 3'b010, 9'h20, 32'h11223344, 32'h0, 1'b0);
        drain();
        rsp_ready = 1'b0;
        issue("rst_pend_lw", 1'b0, 3'b010, 9'h20, 32'h0, 32'h11223344, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 9'h20; req_wdata = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstresp_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstresp_req_ready", 64'(req_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        issue("lw20_old", 1'b0, 3'b010, 9'h20, 32'h0, 32'h11223344, 1'b0);
        drain();

        op64("sd08", 1'b1, 3'b011, 9'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0);
        op64("lwu0c", 1'b0, 3'b110, 9'h0C, 64'h0, 64'h0000000001234567, 1'b0);
        op64("ld08", 1'b0, 3'b011, 9'h08, 64'h0, 64'h0123456789ABCDEF, 1'b0);
        op64("lw08", 1'b0, 3'b010, 9'h08, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0);
        op64("lb0f", 1'b0, 3'b000, 9'h0F, 64'h0, 64'h0000000000000001, 1'b0);
        op64("sh0a", 1'b1, 3'b001, 9'h0A, 64'h000000000000BEEF, 64'h0, 1'b0);
        op64("ld08b", 1'b0, 3'b011, 9'h08, 64'h0, 64'h01234567BEEFCDEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        op64("ld0c_mis", 1'b0, 3'b011, 9'h0C, 64'h0, 64'h0, 1'b1);
`else
        op64("ld0c_mis", 1'b0, 3'b011, 9'h0C, 64'h0, 64'h01234567BEEFCDEF, 1'b0);
`endif
        op64("s100_ill64", 1'b1, 3'b100, 9'h08, 64'hFFFF, 64'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
